// File: rtl/temp_alarm_ctrl.sv
// Temperature alarm controller: block-averages 8-bit samples, then classifies each
// average into NORMAL/WARN/CRIT with hysteresis and debounce, raising a sticky interrupt on CRIT entry.
module temp_alarm_ctrl #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned WARN_HI  = 60,
  parameter int unsigned WARN_LO  = 55,
  parameter int unsigned CRIT_HI  = 80,
  parameter int unsigned CRIT_LO  = 75,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  input  logic       alarm_ack,
  output logic [7:0] avg_temp,
  output logic       avg_valid,
  output logic [1:0] state,
  output logic       warn,
  output logic       crit,
  output logic       alarm_irq
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_WARN   = 2'd1;
  localparam logic [1:0] ST_CRIT   = 2'd2;

  localparam int unsigned ACC_W = 8 + AVG_LOG2;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);

  localparam logic [AVG_LOG2-1:0] LAST_SAMPLE = '1;
  localparam logic [DEB_W-1:0]    DEB_MAX     = DEB_W'(DEBOUNCE);
  localparam logic [7:0]          WARN_HI_T   = 8'(WARN_HI);
  localparam logic [7:0]          WARN_LO_T   = 8'(WARN_LO);
  localparam logic [7:0]          CRIT_HI_T   = 8'(CRIT_HI);
  localparam logic [7:0]          CRIT_LO_T   = 8'(CRIT_LO);

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]          avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;

  logic [DEB_W-1:0]    hi_cnt_q, hi_cnt_d, hi_upd;
  logic [DEB_W-1:0]    crit_cnt_q, crit_cnt_d, crit_upd;
  logic [1:0]          state_q, state_d;
  logic                irq_q, irq_d;

  // The last sample of a block goes straight into the average, so the next
  // block can start on the very next cycle without dropping anything.
  always_comb begin
    sum         = acc_q + ACC_W'(temp_in);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (temp_valid) begin
      if (cnt_q == LAST_SAMPLE) begin
        avg_d       = sum[ACC_W-1:AVG_LOG2];
        avg_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + AVG_LOG2'(1);
      end
    end
  end

  always_comb begin
    hi_upd     = hi_cnt_q;
    crit_upd   = crit_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    crit_cnt_d = crit_cnt_q;
    state_d    = state_q;
    if (avg_valid_q) begin
      if (avg_q >= WARN_HI_T)
        hi_upd = (hi_cnt_q == DEB_MAX) ? DEB_MAX : hi_cnt_q + DEB_W'(1);
      else
        hi_upd = '0;
      if (avg_q >= CRIT_HI_T)
        crit_upd = (crit_cnt_q == DEB_MAX) ? DEB_MAX : crit_cnt_q + DEB_W'(1);
      else
        crit_upd = '0;

      case (state_q)
        ST_NORMAL: begin
          if (crit_upd == DEB_MAX)    state_d = ST_CRIT;
          else if (hi_upd == DEB_MAX) state_d = ST_WARN;
        end
        ST_WARN: begin
          if (crit_upd == DEB_MAX)    state_d = ST_CRIT;
          else if (avg_q <= WARN_LO_T) state_d = ST_NORMAL;
        end
        ST_CRIT: begin
          if (avg_q <= WARN_LO_T)      state_d = ST_NORMAL;
          else if (avg_q <= CRIT_LO_T) state_d = ST_WARN;
        end
        default: state_d = ST_NORMAL;
      endcase

      // Debounce restarts from scratch in whichever state we land in.
      if (state_d != state_q) begin
        hi_cnt_d   = '0;
        crit_cnt_d = '0;
      end else begin
        hi_cnt_d   = hi_upd;
        crit_cnt_d = crit_upd;
      end
    end

    irq_d = irq_q;
    if (state_d == ST_CRIT && state_q != ST_CRIT) irq_d = 1'b1;
    else if (alarm_ack)                           irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      hi_cnt_q    <= '0;
      crit_cnt_q  <= '0;
      state_q     <= ST_NORMAL;
      irq_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      hi_cnt_q    <= hi_cnt_d;
      crit_cnt_q  <= crit_cnt_d;
      state_q     <= state_d;
      irq_q       <= irq_d;
    end
  end

  assign avg_temp  = avg_q;
  assign avg_valid = avg_valid_q;
  assign state     = state_q;
  assign warn      = (state_q != ST_NORMAL);
  assign crit      = (state_q == ST_CRIT);
  assign alarm_irq = irq_q;

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Bench for temp_alarm_ctrl: directed scenarios plus random traffic, every cycle
// compared against a sample-level reference model.
module tb_temp_alarm_ctrl;

  localparam int N        = 4;
  localparam int WARN_HI  = 60;
  localparam int WARN_LO  = 55;
  localparam int CRIT_HI  = 80;
  localparam int CRIT_LO  = 75;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] temp_in = '0;
  logic       temp_valid = 1'b0;
  logic       alarm_ack = 1'b0;
  logic [7:0] avg_temp;
  logic       avg_valid;
  logic [1:0] state;
  logic       warn;
  logic       crit;
  logic       alarm_irq;

  always #5 clk = ~clk;

  temp_alarm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .alarm_ack  (alarm_ack),
    .avg_temp   (avg_temp),
    .avg_valid  (avg_valid),
    .state      (state),
    .warn       (warn),
    .crit       (crit),
    .alarm_irq  (alarm_irq)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: running sum over a block, integer average, and a
  // NORMAL(0)/WARN(1)/CRIT(2) classifier applied one edge after publication.
  int m_sum, m_cnt, m_avg, m_avg_valid, m_state, m_hi, m_cr, m_irq;

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_avg = 0; m_avg_valid = 0;
    m_state = 0; m_hi = 0; m_cr = 0; m_irq = 0;
  endtask

  task automatic model_step(input bit v, input int t, input bit ack);
    int hi, cr, ns;
    bit entered;
    entered = 1'b0;
    if (m_avg_valid != 0) begin
      hi = (m_avg >= WARN_HI) ? ((m_hi + 1 > DEBOUNCE) ? DEBOUNCE : m_hi + 1) : 0;
      cr = (m_avg >= CRIT_HI) ? ((m_cr + 1 > DEBOUNCE) ? DEBOUNCE : m_cr + 1) : 0;
      ns = m_state;
      if (m_state == 0) begin
        if (cr == DEBOUNCE) ns = 2;
        else if (hi == DEBOUNCE) ns = 1;
      end else if (m_state == 1) begin
        if (cr == DEBOUNCE) ns = 2;
        else if (m_avg <= WARN_LO) ns = 0;
      end else begin
        if (m_avg <= WARN_LO) ns = 0;
        else if (m_avg <= CRIT_LO) ns = 1;
      end
      if (ns != m_state) begin
        m_hi = 0; m_cr = 0;
      end else begin
        m_hi = hi; m_cr = cr;
      end
      entered = (ns == 2) && (m_state != 2);
      m_state = ns;
    end
    if (entered) m_irq = 1;
    else if (ack) m_irq = 0;
    m_avg_valid = 0;
    if (v) begin
      m_sum += t;
      m_cnt++;
      if (m_cnt == N) begin
        m_avg = m_sum / N;
        m_avg_valid = 1;
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_avg_temp"},  32'(avg_temp),  32'(m_avg));
    chk({tag, "_avg_valid"}, 32'(avg_valid), 32'(m_avg_valid));
    chk({tag, "_state"},     32'(state),     32'(m_state));
    chk({tag, "_warn"},      32'(warn),      32'(m_state != 0));
    chk({tag, "_crit"},      32'(crit),      32'(m_state == 2));
    chk({tag, "_irq"},       32'(alarm_irq), 32'(m_irq));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; temp_valid = 1'b0; alarm_ack = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
  endtask

  task automatic drive(input bit v, input int t, input bit ack);
    @(negedge clk);
    rst = 1'b0; temp_valid = v; temp_in = 8'(t); alarm_ack = ack;
    @(posedge clk);
    model_step(v, t, ack);
    #1;
    check_all("cyc");
  endtask

  // Four identical samples, then one idle cycle on which the classifier acts.
  task automatic send_avg(input int t, input bit ack_on_class);
    repeat (N) drive(1'b1, t, 1'b0);
    drive(1'b0, 0, ack_on_class);
  endtask

  int bands[6] = '{40, 57, 62, 70, 78, 85};
  int pulses, first_pulse, last_pulse, band, in_group;

  initial begin
    model_reset();
    // Reset state
    do_reset(2);
    chk("reset_state", 32'(state), 32'd0);

    // Plain averaging and truncation
    drive(1, 20, 0); drive(1, 40, 0); drive(1, 60, 0); drive(1, 80, 0);
    chk("avg50_valid", 32'(avg_valid), 32'd1);
    chk("avg50_value", 32'(avg_temp), 32'd50);
    drive(0, 0, 0);
    chk("avg50_pulse_end", 32'(avg_valid), 32'd0);
    chk("avg50_state", 32'(state), 32'd0);
    drive(1, 20, 0); drive(1, 20, 0); drive(1, 20, 0); drive(1, 21, 0);
    chk("avg_trunc", 32'(avg_temp), 32'd20);

    // Escalation to WARN after debounce
    do_reset(1);
    send_avg(62, 0); send_avg(62, 0);
    chk("warn_not_yet", 32'(state), 32'd0);
    send_avg(62, 0);
    chk("warn_entry_state", 32'(state), 32'd1);
    chk("warn_entry_flag", 32'(warn), 32'd1);

    // Debounce restart
    do_reset(1);
    send_avg(62, 0); send_avg(62, 0); send_avg(50, 0); send_avg(62, 0); send_avg(62, 0);
    chk("debounce_restart", 32'(state), 32'd0);

    // CRIT entry, interrupt, ack
    do_reset(1);
    send_avg(85, 0); send_avg(85, 0); send_avg(85, 0);
    chk("crit_state", 32'(state), 32'd2);
    chk("crit_flag", 32'(crit), 32'd1);
    chk("crit_irq", 32'(alarm_irq), 32'd1);
    drive(0, 0, 1);
    chk("ack_clears", 32'(alarm_irq), 32'd0);
    chk("ack_keeps_state", 32'(state), 32'd2);

    // Hysteresis walk-down from CRIT
    send_avg(78, 0);
    chk("hyst_78", 32'(state), 32'd2);
    send_avg(70, 0);
    chk("hyst_70", 32'(state), 32'd1);
    send_avg(57, 0);
    chk("hyst_57", 32'(state), 32'd1);
    send_avg(55, 0);
    chk("hyst_55", 32'(state), 32'd0);

    // Ack on the entry edge: set wins
    do_reset(1);
    send_avg(85, 0); send_avg(85, 0); send_avg(85, 1);
    chk("ack_on_entry_irq", 32'(alarm_irq), 32'd1);
    send_avg(40, 0);
    chk("crit_to_normal", 32'(state), 32'd0);

    // Reset mid-average discards partial sum
    do_reset(1);
    drive(1, 90, 0); drive(1, 90, 0);
    do_reset(1);
    drive(1, 10, 0); drive(1, 10, 0); drive(1, 10, 0); drive(1, 10, 0);
    chk("midavg_reset", 32'(avg_temp), 32'd10);

    // Back-to-back samples
    pulses = 0; first_pulse = -1; last_pulse = -1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 30 + i, 0);
      if (avg_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_spacing", 32'(last_pulse - first_pulse), 32'd4);

    // Random traffic around the thresholds
    do_reset(1);
    band = bands[0]; in_group = 0;
    for (int i = 0; i < 600; i++) begin
      bit v;
      int t;
      v = ($urandom_range(0, 3) != 0);
      if (v && in_group == 0) band = bands[$urandom_range(0, 5)];
      t = band + int'($urandom_range(0, 6)) - 3;
      if (v) in_group = (in_group + 1) % N;
      drive(v, t, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
